// File: rtl/rpn_stack.sv
// LIFO operand stack for the RPN datapath: push, pop, replace-top, two-operand
// reduce and clear, with full/empty/count status and sticky error flags.
module rpn_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 100
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         PUSH_STB,
    input  logic [WIDTH-1:0]             PUSH_DAT,
    input  logic                         POP_STB,
    input  logic                         POP2_STB,
    input  logic                         CLR_STB,
    output logic [WIDTH-1:0]             TOS_DAT,
    output logic [WIDTH-1:0]             NOS_DAT,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ERR,
    output logic [1:0]                   ERR_CODE
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    localparam logic [2:0] OP_IDLE = 3'd0;
    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_POP2 = 3'd2;
    localparam logic [2:0] OP_REPL = 3'd3;
    localparam logic [2:0] OP_PUSH = 3'd4;
    localparam logic [2:0] OP_POP  = 3'd5;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [1:0]       err_code;

    logic [2:0]       op_sel;
    logic [CW-1:0]    count_nxt;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             ovf;
    logic             udf;
    logic             clr;

    logic [AW-1:0]    tos_idx;
    logic [AW-1:0]    nos_idx;

    // Only the highest-priority strobe acts; the rest are silently dropped.
    always_comb begin
        op_sel = OP_IDLE;
        if (CLR_STB)                 op_sel = OP_CLR;
        else if (POP2_STB)           op_sel = OP_POP2;
        else if (PUSH_STB && POP_STB) op_sel = OP_REPL;
        else if (PUSH_STB)           op_sel = OP_PUSH;
        else if (POP_STB)            op_sel = OP_POP;
    end

    always_comb begin
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = '0;
        ovf       = 1'b0;
        udf       = 1'b0;
        clr       = 1'b0;
        case (op_sel)
            OP_CLR: begin
                clr       = 1'b1;
                count_nxt = CNT_ZERO;
            end
            OP_POP2: begin
                if (count >= CNT_TWO) begin
                    wr_en     = 1'b1;
                    wr_idx    = AW'(count - CNT_TWO);
                    count_nxt = count - CNT_ONE;
                end else begin
                    udf = 1'b1;
                end
            end
            OP_REPL: begin
                if (count != CNT_ZERO) begin
                    wr_en  = 1'b1;
                    wr_idx = AW'(count - CNT_ONE);
                end else begin
                    udf = 1'b1;
                end
            end
            OP_PUSH: begin
                if (count != CNT_MAX) begin
                    wr_en     = 1'b1;
                    wr_idx    = AW'(count);
                    count_nxt = count + CNT_ONE;
                end else begin
                    ovf = 1'b1;
                end
            end
            OP_POP: begin
                if (count != CNT_ZERO) begin
                    count_nxt = count - CNT_ONE;
                end else begin
                    udf = 1'b1;
                end
            end
            default: begin
                count_nxt = count;
            end
        endcase
    end

    // Storage carries no reset; COUNT alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_en) begin
            mem[wr_idx] <= PUSH_DAT;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count    <= CNT_ZERO;
            err_code <= 2'b00;
        end else begin
            count <= count_nxt;
            if (clr) begin
                err_code <= 2'b00;
            end else begin
                err_code <= err_code | {udf, ovf};
            end
        end
    end

    assign tos_idx = AW'(count - CNT_ONE);
    assign nos_idx = AW'(count - CNT_TWO);

    always_comb begin
        TOS_DAT = '0;
        NOS_DAT = '0;
        if (count != CNT_ZERO) begin
            TOS_DAT = mem[tos_idx];
        end
        if (count >= CNT_TWO) begin
            NOS_DAT = mem[nos_idx];
        end
    end

    assign COUNT    = count;
    assign EMPTY    = (count == CNT_ZERO);
    assign FULL     = (count == CNT_MAX);
    assign ERR      = |err_code;
    assign ERR_CODE = err_code;

endmodule

// File: tb/tb_rpn_stack.sv
// Bench for rpn_stack: directed scenarios plus random traffic on a DEPTH=100
// and a DEPTH=4 instance, both checked each cycle against an array model.
module tb_rpn_stack;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        PUSH_STB = 1'b0;
    logic [31:0] PUSH_DAT = '0;
    logic        POP_STB = 1'b0;
    logic        POP2_STB = 1'b0;
    logic        CLR_STB = 1'b0;

    logic [31:0] tos_a, nos_a, tos_b, nos_b;
    logic [6:0]  count_a;
    logic [2:0]  count_b;
    logic        empty_a, full_a, err_a, empty_b, full_b, err_b;
    logic [1:0]  ec_a, ec_b;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: index 0 mirrors the DEPTH=100 instance, index 1 the DEPTH=4 one.
    logic [31:0] m_mem [2][128];
    int          m_cnt [2];
    logic [1:0]  m_ec  [2];

    always #5 CLK = ~CLK;

    rpn_stack #(.WIDTH(32), .DEPTH(100)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .PUSH_STB(PUSH_STB), .PUSH_DAT(PUSH_DAT),
        .POP_STB(POP_STB), .POP2_STB(POP2_STB), .CLR_STB(CLR_STB),
        .TOS_DAT(tos_a), .NOS_DAT(nos_a), .COUNT(count_a), .EMPTY(empty_a),
        .FULL(full_a), .ERR(err_a), .ERR_CODE(ec_a)
    );

    rpn_stack #(.WIDTH(32), .DEPTH(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .PUSH_STB(PUSH_STB), .PUSH_DAT(PUSH_DAT),
        .POP_STB(POP_STB), .POP2_STB(POP2_STB), .CLR_STB(CLR_STB),
        .TOS_DAT(tos_b), .NOS_DAT(nos_b), .COUNT(count_b), .EMPTY(empty_b),
        .FULL(full_b), .ERR(err_b), .ERR_CODE(ec_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int dep;
            int c;
            dep = (k == 0) ? 100 : 4;
            c   = m_cnt[k];
            if (!RST_N) begin
                m_cnt[k] = 0;
                m_ec[k]  = 2'b00;
            end else if (CLR_STB) begin
                m_cnt[k] = 0;
                m_ec[k]  = 2'b00;
            end else if (POP2_STB) begin
                if (c >= 2) begin
                    m_mem[k][c-2] = PUSH_DAT;
                    m_cnt[k] = c - 1;
                end else m_ec[k][1] = 1'b1;
            end else if (PUSH_STB && POP_STB) begin
                if (c >= 1) m_mem[k][c-1] = PUSH_DAT;
                else m_ec[k][1] = 1'b1;
            end else if (PUSH_STB) begin
                if (c < dep) begin
                    m_mem[k][c] = PUSH_DAT;
                    m_cnt[k] = c + 1;
                end else m_ec[k][0] = 1'b1;
            end else if (POP_STB) begin
                if (c >= 1) m_cnt[k] = c - 1;
                else m_ec[k][1] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] m_tos(input int k);
        return (m_cnt[k] > 0) ? m_mem[k][m_cnt[k]-1] : 32'd0;
    endfunction

    function automatic logic [31:0] m_nos(input int k);
        return (m_cnt[k] > 1) ? m_mem[k][m_cnt[k]-2] : 32'd0;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("a_count", 32'(count_a), 32'(m_cnt[0]));
            chk("a_tos",   tos_a, m_tos(0));
            chk("a_nos",   nos_a, m_nos(0));
            chk("a_empty", 32'(empty_a), 32'(m_cnt[0] == 0));
            chk("a_full",  32'(full_a),  32'(m_cnt[0] == 100));
            chk("a_err",   32'(err_a),   32'(m_ec[0] != 2'b00));
            chk("a_ecode", 32'(ec_a),    32'(m_ec[0]));
            chk("b_count", 32'(count_b), 32'(m_cnt[1]));
            chk("b_tos",   tos_b, m_tos(1));
            chk("b_nos",   nos_b, m_nos(1));
            chk("b_empty", 32'(empty_b), 32'(m_cnt[1] == 0));
            chk("b_full",  32'(full_b),  32'(m_cnt[1] == 4));
            chk("b_err",   32'(err_b),   32'(m_ec[1] != 2'b00));
            chk("b_ecode", 32'(ec_b),    32'(m_ec[1]));
        end
    end

    task automatic step(input logic rst_n, input logic push, input logic pop,
                        input logic pop2, input logic clr, input logic [31:0] dat);
        RST_N    = rst_n;
        PUSH_STB = push;
        POP_STB  = pop;
        POP2_STB = pop2;
        CLR_STB  = clr;
        PUSH_DAT = dat;
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic push_v(input logic [31:0] d); step(1, 1, 0, 0, 0, d); endtask
    task automatic pop_v();                      step(1, 0, 1, 0, 0, 0); endtask
    task automatic clr_v();                      step(1, 0, 0, 0, 1, 0); endtask

    initial begin
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_ec[0] = 2'b00; m_ec[1] = 2'b00;

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_tos",   tos_a, 32'd0);

        push_v(5);
        push_v(7);
        chk("lit_cnt2",  32'(count_a), 32'd2);
        chk("lit_tos7",  tos_a, 32'd7);
        chk("lit_nos5",  nos_a, 32'd5);
        chk("lit_nempty", 32'(empty_a), 32'd0);
        step(1, 0, 0, 1, 0, 12);
        chk("lit_red_cnt", 32'(count_a), 32'd1);
        chk("lit_red_tos", tos_a, 32'd12);
        chk("lit_red_nos", nos_a, 32'd0);
        chk("lit_red_err", 32'(err_a), 32'd0);

        clr_v();
        for (int i = 1; i <= 4; i++) push_v(32'(i));
        chk("lit_b_full", 32'(full_b), 32'd1);
        push_v(9);
        chk("lit_ovf_cnt", 32'(count_b), 32'd4);
        chk("lit_ovf_tos", tos_b, 32'd4);
        chk("lit_ovf_ec",  32'(ec_b), 32'd1);
        step(1, 1, 1, 0, 0, 9);
        chk("lit_repl_tos", tos_b, 32'd9);
        chk("lit_repl_cnt", 32'(count_b), 32'd4);
        chk("lit_repl_ec",  32'(ec_b), 32'd1);

        clr_v();
        pop_v();
        chk("lit_udf_ec",  32'(ec_a), 32'd2);
        chk("lit_udf_cnt", 32'(count_a), 32'd0);
        push_v(3);
        step(1, 0, 0, 1, 0, 44);
        chk("lit_udf2_ec",  32'(ec_a), 32'd2);
        chk("lit_udf2_cnt", 32'(count_a), 32'd1);
        chk("lit_udf2_tos", tos_a, 32'd3);
        clr_v();
        chk("lit_clr_ec", 32'(ec_a), 32'd0);
        chk("lit_clr_err", 32'(err_a), 32'd0);

        push_v(1); push_v(2); push_v(3);
        step(1, 1, 0, 1, 1, 77);
        chk("lit_prio_cnt", 32'(count_a), 32'd0);
        chk("lit_prio_err", 32'(err_a), 32'd0);
        push_v(4); push_v(5);
        step(1, 1, 0, 1, 0, 8);
        chk("lit_p2p_cnt", 32'(count_a), 32'd1);
        chk("lit_p2p_tos", tos_a, 32'd8);

        clr_v();
        for (int i = 0; i < 100; i++) push_v(32'(1000 + i));
        chk("lit_full100", 32'(full_a), 32'd1);
        for (int j = 0; j < 100; j++) begin
            pop_v();
            if (j < 99) chk("lit_rev_tos", tos_a, 32'(1000 + 98 - j));
        end
        chk("lit_drain_empty", 32'(empty_a), 32'd1);
        chk("lit_drain_err", 32'(err_a), 32'd0);

        push_v(21); push_v(22); push_v(23);
        step(0, 1, 0, 0, 0, 99);
        chk("lit_rst_cnt", 32'(count_a), 32'd0);
        chk("lit_rst_tos", tos_a, 32'd0);
        chk("lit_rst_ec", 32'(ec_b), 32'd0);
        push_v(6);
        chk("lit_post_cnt", 32'(count_a), 32'd1);
        chk("lit_post_tos", tos_a, 32'd6);

        for (int i = 0; i < 4000; i++) begin
            int ph;
            int p_push;
            int p_pop;
            ph = (i / 400) % 4;
            p_push = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
            p_pop  = (ph == 0) ? 10 : (ph == 1) ? 70 : 40;
            step(($urandom_range(999) >= 4),
                 ($urandom_range(99) < p_push),
                 ($urandom_range(99) < p_pop),
                 ($urandom_range(99) < 10),
                 ($urandom_range(999) < 8),
                 $urandom);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
